// File: rtl/pipe_ctrl.sv
// Pipeline control: merges per-stage stall requests, sequences multi-cycle EX
// operations with a countdown, issues registered flushes and counts stall cycles.
module pipe_ctrl #(
    parameter int NSTAGE   = 6,
    parameter int MC_STAGE = 3,
    parameter int CNTW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              mc_start,
    input  logic [CNTW-1:0]   mc_len,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_done,
    output logic              busy,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        MC   = 1'b1
    } state_t;

    localparam logic [NSTAGE-1:0] MC_BIT = NSTAGE'(1) << MC_STAGE;
    localparam logic [CNTW-1:0]   CNT_ONE = CNTW'(1);

    state_t            state, state_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic              mc_req;
    logic [NSTAGE-1:0] req_vec;
    logic [NSTAGE-1:0] therm;
    logic              acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A flush aborts any operation in flight; its mc_done never appears.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_req    = 1'b0;
        mc_done   = 1'b0;
        case (state)
            IDLE: begin
                if (mc_start && (mc_len != '0)) begin
                    mc_req    = 1'b1;
                    state_nxt = MC;
                    cnt_nxt   = mc_len;
                end
            end
            MC: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt > CNT_ONE) begin
                    mc_req = 1'b1;
                end
                if (cnt == CNT_ONE) begin
                    mc_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (flush_req) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    assign busy    = (state == MC);
    assign req_vec = stallreq | (mc_req ? MC_BIT : '0);

    // Thermometer fill: every stage at or below the highest requester holds.
    always_comb begin
        therm = '0;
        acc   = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            acc      = acc | req_vec[k];
            therm[k] = acc;
        end
    end

    assign stall = (flush || !rst) ? '0 : therm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush  <= 1'b0;
            new_pc <= '0;
        end else begin
            flush <= flush_req;
            if (flush_req) begin
                new_pc <= flush_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall[0] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle-by-cycle vector table fed through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_pipe_ctrl;

    typedef struct {
        logic [5:0]  sr;
        logic        st;
        logic [5:0]  len;
        logic        fr;
        logic [31:0] fpc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_done;
        logic        e_busy;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stallreq;
    logic        mc_start;
    logic [5:0]  mc_len;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_done;
    logic        busy;
    logic [31:0] stall_cnt;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start),
        .mc_len(mc_len), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .mc_done(mc_done),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic [5:0] sr, input logic st, input logic [5:0] len,
                           input logic fr, input logic [31:0] fpc, input logic [5:0] e_stall,
                           input logic e_flush, input logic [31:0] e_pc, input logic e_done,
                           input logic e_busy, input logic [31:0] e_cnt);
        vec_t v;
        v.sr = sr; v.st = st; v.len = len; v.fr = fr; v.fpc = fpc;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc;
        v.e_done = e_done; v.e_busy = e_busy; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check_field({tag, ".stall"},     {26'd0, stall}, {26'd0, e.e_stall});
        check_field({tag, ".flush"},     {31'd0, flush}, {31'd0, e.e_flush});
        check_field({tag, ".new_pc"},    new_pc, e.e_pc);
        check_field({tag, ".mc_done"},   {31'd0, mc_done}, {31'd0, e.e_done});
        check_field({tag, ".busy"},      {31'd0, busy}, {31'd0, e.e_busy});
        check_field({tag, ".stall_cnt"}, stall_cnt, e.e_cnt);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        stallreq  = v.sr;
        mc_start  = v.st;
        mc_len    = v.len;
        flush_req = v.fr;
        flush_pc  = v.fpc;
        exp_q.push_back(v);
    endtask

    task automatic expect_now(input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                              input logic e_done, input logic e_busy, input logic [31:0] e_cnt);
        vec_t v;
        v.sr = '0; v.st = 1'b0; v.len = '0; v.fr = 1'b0; v.fpc = '0;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc;
        v.e_done = e_done; v.e_busy = e_busy; v.e_cnt = e_cnt;
        exp_q.push_back(v);
    endtask

    initial begin
        rst = 1'b0; stallreq = '0; mc_start = 1'b0; mc_len = '0;
        flush_req = 1'b0; flush_pc = '0;

        //       sr        st len   fr fpc           stall     fl pc            dn bz cnt
        add_vec(6'b000100, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 32'h0,        0, 0, 0);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 1);
        add_vec(6'b000000, 1, 6'd4, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 1);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1, 2);
        add_vec(6'b000000, 1, 6'd2, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1, 3);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1, 4);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 1, 5);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 5);
        add_vec(6'b000000, 1, 6'd5, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 5);
        add_vec(6'b010000, 0, 6'd0, 0, 32'h0,        6'b011111, 0, 32'h0,        0, 1, 6);
        add_vec(6'b010000, 0, 6'd0, 0, 32'h0,        6'b011111, 0, 32'h0,        0, 1, 7);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1, 8);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1, 9);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        1, 1, 10);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, 10);
        add_vec(6'b000000, 1, 6'd8, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, 10);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 1, 11);
        add_vec(6'b000000, 0, 6'd0, 1, 32'hBFC00380, 6'b001111, 0, 32'h0,        0, 1, 12);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 1, 32'hBFC00380, 0, 0, 13);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0, 0, 13);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0, 0, 13);
        add_vec(6'b000000, 1, 6'd0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0, 0, 13);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0, 0, 13);
        add_vec(6'b000000, 1, 6'd1, 0, 32'h0,        6'b001111, 0, 32'hBFC00380, 0, 0, 13);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 1, 1, 14);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0, 0, 14);
        add_vec(6'b000000, 1, 6'd3, 1, 32'h00001234, 6'b001111, 0, 32'hBFC00380, 0, 0, 14);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 1, 32'h00001234, 0, 0, 15);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h00001234, 0, 0, 15);
        add_vec(6'b100000, 0, 6'd0, 0, 32'h0,        6'b111111, 0, 32'h00001234, 0, 0, 15);
        add_vec(6'b000001, 0, 6'd0, 0, 32'h0,        6'b000001, 0, 32'h00001234, 0, 0, 16);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h00001234, 0, 0, 17);
        add_vec(6'b000000, 0, 6'd0, 1, 32'h80000000, 6'b000000, 0, 32'h00001234, 0, 0, 17);
        add_vec(6'b001000, 0, 6'd0, 0, 32'h0,        6'b000000, 1, 32'h80000000, 0, 0, 17);
        add_vec(6'b000000, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h80000000, 0, 0, 17);

        // Values held during reset.
        @(negedge clk);
        expect_now(6'b0, 0, 32'h0, 0, 0, 0);
        checkOutput("in_reset");
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges in the middle of an MC operation.
        @(posedge clk);
        #1 mc_start = 1'b1; mc_len = 6'd6; stallreq = '0; flush_req = 1'b0;
        @(posedge clk);
        #1 mc_start = 1'b0; mc_len = '0;
        @(negedge clk);
        expect_now(6'b001111, 0, 32'h80000000, 0, 1, 18);
        checkOutput("pre_reset");
        #2 rst = 1'b0;
        #1;
        expect_now(6'b0, 0, 32'h0, 0, 0, 0);
        checkOutput("async_reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Sequencer restarts normally after reset, L=2.
        @(posedge clk);
        #1 mc_start = 1'b1; mc_len = 6'd2;
        @(negedge clk);
        expect_now(6'b001111, 0, 32'h0, 0, 0, 0);
        checkOutput("post_c0");
        @(posedge clk);
        #1 mc_start = 1'b0; mc_len = '0;
        @(negedge clk);
        expect_now(6'b001111, 0, 32'h0, 0, 1, 1);
        checkOutput("post_c1");
        @(negedge clk);
        expect_now(6'b000000, 0, 32'h0, 1, 1, 2);
        checkOutput("post_c2");
        @(negedge clk);
        expect_now(6'b000000, 0, 32'h0, 0, 0, 2);
        checkOutput("post_c3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the five-stage core, replacing the fixed stall generator. It merges per-stage stall requests, sequences multi-cycle EX operations (divider/multiplier) with an internal countdown, and issues registered pipeline flushes with a redirect PC. It also keeps a saturating stall-cycle counter for performance debug. It drives the `stall` bus consumed by IF, ID, EX, MEM and WB.

## Interface
- `NSTAGE`, default 6: stall bus width. Bit 0 is PC, 1 is IF, 2 is ID, 3 is EX, 4 is MEM, 5 is WB.
- `MC_STAGE`, default 3: stall-bus index of the stage that owns multi-cycle operations.
- `CNTW`, default 6: width of the multi-cycle length field.
- `clk`, input, 1: the single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset. The block is in reset while `rst`=0.
- `stallreq`, input, NSTAGE: bit i is stage i's combinational stall request.
- `mc_start`, input, 1: a multi-cycle operation is issued in stage MC_STAGE this cycle.
- `mc_len`, input, CNTW: length of that operation in cycles.
- `flush_req`, input, 1: exception or redirect request.
- `flush_pc`, input, 32: redirect target, sampled with `flush_req`.
- `stall`, output, NSTAGE: bit k=1 means stage k holds its register this cycle.
- `flush`, output, 1: one-cycle pulse that clears all pipeline registers.
- `new_pc`, output, 32: redirect target, valid while `flush`=1.
- `mc_done`, output, 1: one-cycle pulse; the multi-cycle result is available this cycle.
- `busy`, output, 1: the multi-cycle sequencer is active.
- `stall_cnt`, output, 32: number of cycles with `stall[0]`=1. Saturates at 0xFFFF_FFFF.

## Operation
- State machine states: IDLE and MC. Internal counter `cnt` is CNTW bits wide.
- IDLE to MC: taken when `mc_start`=1 and `mc_len`!=0. Load `cnt`←`mc_len`.
  - If `mc_len`=0, `mc_start` is a no-op: no state change, no stall, no `mc_done`.
- In MC:
  - `cnt` decrements each cycle.
  - When `cnt`=1, return to IDLE. `mc_done`=1 that cycle (combinational).
  - `mc_start` is ignored while in MC.
- Multi-cycle stall request, `mc_req`:
  - Asserted in IDLE when `mc_start`=1 and `mc_len`!=0.
  - Asserted in MC when `cnt`>1.
- Request vector: `r` = `stallreq` OR (`mc_req` shifted to bit MC_STAGE).
- Stall bus: `h` is the highest set bit of `r`. `stall[k]`=1 for all k≤h; `stall`=0 when `r`=0.
  - Stage k+1 inserts a bubble when `stall[k]`=1 and `stall[k+1]`=0. That is the stage's responsibility, not this block's.
- Flush:
  - `flush_req`=1 at edge t registers `flush`←1 and `new_pc`←`flush_pc`. `flush` is high for one cycle; `new_pc` holds until the next flush.
  - While `flush`=1, `stall` is forced to 0.
  - `flush_req` takes priority over the sequencer. At the same edge, state←IDLE and `cnt`←0, and no `mc_done` is produced for the aborted operation.
  - Simultaneous `flush_req` and `mc_start`: the flush wins and the operation is not started.
- `busy` = (state==MC).
- `stall_cnt` increments on every edge where `stall[0]`=1, and saturates.

## Timing
- Reset values: state IDLE, `cnt`=0, `stall`=0, `flush`=0, `new_pc`=0, `mc_done`=0, `busy`=0, `stall_cnt`=0.
- Reset asserts immediately and asynchronously, including in the middle of an MC sequence.
- `stall` and `mc_done` are combinational from the inputs and state, with zero latency.
- `flush` and `new_pc` are registered, with one-cycle latency from `flush_req`.
- A multi-cycle operation with `mc_len`=L, started in cycle 0:
  - `stall[MC_STAGE:0]`=1 in cycles 0..L-1.
  - `busy`=1 in cycles 1..L.
  - `mc_done`=1 in cycle L with no stall from the sequencer.
  - State is IDLE in cycle L+1.
- The stall stays L cycles even when higher stages also request stalls. Overlapping requests simply OR together.

## Test plan
All scenarios use default parameters.
- **Stage request:** `stallreq`=6'b000100 → `stall`=6'b000111 in the same cycle. Release it → `stall`=0; `stall_cnt` increased by 1.
- **Multi-cycle op:** `mc_start`=1, `mc_len`=4 at cycle 0 →
  - `stall`=6'b001111 in cycles 0–3; `busy` high in cycles 1–4.
  - `mc_done`=1 and `stall`=0 in cycle 4.
  - `stall_cnt`=4 afterwards.
  - A second `mc_start` in cycle 2 is ignored.
- **Combined request:** an active MC operation plus `stallreq`=6'b010000 → `stall`=6'b011111. Drop `stallreq` → `stall`=6'b001111.
- **Flush during MC:** MC with `mc_len`=8; `flush_req`=1 with `flush_pc`=0xBFC0_0380 in cycle 2 →
  - cycle 3: `flush`=1, `new_pc`=0xBFC0_0380, `stall`=0, `busy`=0.
  - cycle 4: `flush`=0; `mc_done` never asserts.
- **Edge cases:**
  - `mc_start` with `mc_len`=0 → no stall, no `busy`, no `mc_done`.
  - `mc_start` with `mc_len`=1 → `stall`=6'b001111 in cycle 0, `mc_done`=1 in cycle 1.
  - Simultaneous `flush_req` and `mc_start` → the flush occurs and `busy` stays 0.
- **Reset:** drive `rst`=0 mid-MC between clock edges → all outputs reach their reset values immediately. After `rst`=1, `mc_start` works normally.
